mvb_encode: RTL and testbench



---
 rtl/mvb_encode_if.sv | 23 ++
 rtl/mvb_encode.sv | 153 +++++++++++++++
 tb/tb_mvb_encode.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mvb_encode_if.sv
// Request/line bundle between the transmit word FIFO, the frame requester and mvb_encode.
interface mvb_encode_if;
  logic        tx_start;
  logic        frame_type;
  logic [4:0]  frame_length;
  logic [15:0] data_in;
  logic        word_rd;
  logic        tx_out;
  logic        tx_en;
  logic        busy;
  logic        tx_done;
  logic        len_error;

  modport master (
    output tx_start, frame_type, frame_length, data_in,
    input  word_rd, tx_out, tx_en, busy, tx_done, len_error
  );

  modport slave (
    input  tx_start, frame_type, frame_length, data_in,
    output word_rd, tx_out, tx_en, busy, tx_done, len_error
  );
endinterface

// File: rtl/mvb_encode.sv
// MVB frame transmitter: start delimiter, Manchester data words from a FIFO,
// one 8-bit check per 64-bit group, and the NL end delimiter.
module mvb_encode #(
  parameter int CLK_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  mvb_encode_if.slave bus
);
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLK_PER_BIT - 1);

  // Symbol code is {first-half level, second-half level}.
  localparam logic [1:0] S_ONE  = 2'b10;
  localparam logic [1:0] S_ZERO = 2'b01;
  localparam logic [1:0] S_NH   = 2'b11;
  localparam logic [1:0] S_NL   = 2'b00;

  typedef enum logic [2:0] {ST_IDLE, ST_DELIM, ST_DATA, ST_CHECK, ST_END} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [3:0]    bidx;
  logic [4:0]    widx, nwords;
  logic          ftype;
  logic [15:0]   sh, hold;
  logic [6:0]    crc;
  logic [7:0]    chk, chk_val;
  logic [1:0]    cur_sym, nsym;
  logic          tx_out, tx_en, busy, word_rd, tx_done, len_error, rd_pipe;
  logic          bit_end, len_ok, req_ok, last_word, grp_end, more, new_word, nbit;

  function automatic logic [1:0] delim_sym(input logic slv, input logic [3:0] i);
    logic [17:0] tbl;
    logic [3:0]  k;
    tbl = slv ? {S_ONE, S_ONE, S_ONE, S_ONE, S_NL, S_NH, S_ONE, S_NL, S_NH}
              : {S_ONE, S_NH, S_NL, S_ZERO, S_NH, S_NL, S_ZERO, S_ZERO, S_ZERO};
    if (i > 4'd8) return S_NL;
    k = 4'd8 - i;
    return tbl[{k, 1'b0} +: 2];
  endfunction

  // x^7+x^6+x^5+x^2+1, MSB-first serial update
  function automatic logic [6:0] crc_step(input logic [6:0] c, input logic b);
    return {c[5:0], 1'b0} ^ ((c[6] ^ b) ? 7'h65 : 7'h00);
  endfunction

  assign bit_end   = (cnt == BIT_END);
  assign len_ok    = (bus.frame_length != 5'd0) &&
                     ((bus.frame_length & (bus.frame_length - 5'd1)) == 5'd0);
  assign req_ok    = !bus.frame_type || len_ok;
  assign last_word = (widx == nwords - 5'd1);
  assign grp_end   = last_word || (widx[1:0] == 2'd3);
  assign more      = (widx != nwords);
  assign new_word  = (state != ST_DATA) || (bidx == 4'd15);
  assign nbit      = new_word ? hold[15] : sh[15];
  assign chk_val   = ~{crc, ^crc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.tx_start && req_ok) state_nxt = ST_DELIM;
      ST_DELIM: if (bit_end && bidx == 4'd8) state_nxt = ST_DATA;
      ST_DATA:  if (bit_end && bidx == 4'd15 && grp_end) state_nxt = ST_CHECK;
      ST_CHECK: if (bit_end && bidx == 4'd7) state_nxt = more ? ST_DATA : ST_END;
      ST_END:   if (bit_end) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Symbol of the bit starting at the next bit boundary.
  always_comb begin
    nsym = S_NL;
    case (state_nxt)
      ST_DELIM: nsym = delim_sym(ftype, bidx + 4'd1);
      ST_DATA:  nsym = nbit ? S_ONE : S_ZERO;
      ST_CHECK: nsym = ((state == ST_DATA) ? chk_val[7] : chk[7]) ? S_ONE : S_ZERO;
      default:  nsym = S_NL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0; bidx <= '0; widx <= '0; nwords <= '0; ftype <= 1'b0;
      sh <= '0; hold <= '0; crc <= '0; chk <= '0; cur_sym <= S_NL;
      tx_out <= 1'b0; tx_en <= 1'b0; busy <= 1'b0; word_rd <= 1'b0;
      tx_done <= 1'b0; len_error <= 1'b0; rd_pipe <= 1'b0;
    end else begin
      word_rd   <= 1'b0;
      tx_done   <= 1'b0;
      len_error <= 1'b0;
      rd_pipe   <= word_rd;
      if (rd_pipe) hold <= bus.data_in;
      if (state == ST_IDLE) begin
        cnt <= '0;
        if (bus.tx_start) begin
          if (req_ok) begin
            busy    <= 1'b1;
            tx_en   <= 1'b1;
            tx_out  <= 1'b1;
            cur_sym <= S_ONE;
            bidx    <= '0;
            widx    <= '0;
            ftype   <= bus.frame_type;
            nwords  <= bus.frame_type ? bus.frame_length : 5'd1;
          end else begin
            len_error <= 1'b1;
          end
        end
      end else begin
        cnt <= bit_end ? '0 : cnt + CW'(1);
        if (cnt == HALF_END) tx_out <= cur_sym[0];
        if (bit_end) begin
          if (state == ST_END) begin
            busy    <= 1'b0;
            tx_en   <= 1'b0;
            tx_done <= 1'b1;
            tx_out  <= 1'b0;
          end else begin
            cur_sym <= nsym;
            tx_out  <= nsym[1];
            bidx    <= (state_nxt != state) ? 4'd0 : bidx + 4'd1;
            if (state == ST_DATA && bidx == 4'd15) widx <= widx + 5'd1;
            if (state_nxt == ST_DATA) begin
              sh  <= new_word ? {hold[14:0], 1'b0} : {sh[14:0], 1'b0};
              crc <= crc_step((state == ST_DATA) ? crc : 7'd0, nbit);
            end
            if (state_nxt == ST_CHECK)
              chk <= {((state == ST_DATA) ? chk_val[6:0] : chk[6:0]), 1'b0};
          end
          // Fetch one bit time ahead of the word that follows this field.
          if ((state == ST_DELIM && bidx == 4'd7) ||
              (state == ST_DATA  && bidx == 4'd14 && !grp_end) ||
              (state == ST_CHECK && bidx == 4'd6 && more))
            word_rd <= 1'b1;
        end
      end
    end
  end

  assign bus.word_rd   = word_rd;
  assign bus.tx_out    = tx_out;
  assign bus.tx_en     = tx_en;
  assign bus.busy      = busy;
  assign bus.tx_done   = tx_done;
  assign bus.len_error = len_error;
endmodule

// File: tb/tb_mvb_encode.sv
// Directed bench for mvb_encode: decodes the line per half-bit and compares
// against hand values and a polynomial-division check model.
module tb_mvb_encode;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mvb_encode_if bif();
  mvb_encode #(.CLK_PER_BIT(16)) dut (.clk(clk), .rst(rst), .bus(bif));

  localparam logic [1:0] ONE = 2'b10, ZERO = 2'b01, NH = 2'b11, NL = 2'b00;

  int          n_cmp = 0, n_err = 0;
  logic [15:0] wmem [16];
  int          fifo_idx = 0;
  logic        line [$];
  int          rd_pos [$];
  int          en_cnt, lerr_cnt, busy_first;
  logic [1:0]  exp_sym [$];
  int          exp_rd [$];
  logic [7:0]  exp_chk [$];
  int          chk_bit [$];
  logic [7:0]  obs_chk0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Upstream FIFO: next word appears 1 clk after the read strobe.
  initial begin
    bif.data_in = '0;
    forever begin
      @(posedge clk);
      if (bif.word_rd === 1'b1) begin
        #1;
        bif.data_in = wmem[fifo_idx % 16];
        fifo_idx++;
      end
    end
  end

  // Check byte by long division of (group bits * x^7) by 0xE5.
  function automatic logic [7:0] model_chk(input logic bits [$]);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < bits.size() + 7; i++) begin
      r = {r[6:0], (i < bits.size()) ? bits[i] : 1'b0};
      if (r[7]) r = r ^ 8'hE5;
    end
    return ~{r[6:0], ^r[6:0]};
  endfunction

  task automatic build_exp(input logic ft, input int nw);
    logic [1:0] dm [9];
    logic       gbits [$];
    logic [7:0] c;
    int         gw;
    exp_sym.delete(); exp_rd.delete(); exp_chk.delete(); chk_bit.delete();
    if (ft) dm = '{ONE, ONE, ONE, ONE, NL, NH, ONE, NL, NH};
    else    dm = '{ONE, NH, NL, ZERO, NH, NL, ZERO, ZERO, ZERO};
    for (int i = 0; i < 9; i++) exp_sym.push_back(dm[i]);
    gw = (nw < 4) ? nw : 4;
    for (int w = 0; w < nw; w++) begin
      exp_rd.push_back(16 * exp_sym.size() - 16);
      for (int b = 15; b >= 0; b--) begin
        exp_sym.push_back(wmem[w][b] ? ONE : ZERO);
        gbits.push_back(wmem[w][b]);
      end
      if ((w + 1) % gw == 0) begin
        c = model_chk(gbits);
        chk_bit.push_back(exp_sym.size());
        exp_chk.push_back(c);
        for (int b = 7; b >= 0; b--) exp_sym.push_back(c[b] ? ONE : ZERO);
        gbits.delete();
      end
    end
    exp_sym.push_back(NL);
  endtask

  task automatic start(input logic ft, input logic [4:0] len);
    @(posedge clk); #1;
    bif.tx_start = 1'b1; bif.frame_type = ft; bif.frame_length = len;
    @(posedge clk); #1;
    bif.tx_start = 1'b0;
  endtask

  // Record one frame per clk until tx_done; optional mid-frame poke and back-to-back start.
  task automatic capture(input int poke, input bit b2b);
    bit done;
    int n;
    done = 0; n = 0;
    line.delete(); rd_pos.delete();
    en_cnt = 0; lerr_cnt = 0; busy_first = 0;
    while (!done && n < 6000) begin
      @(negedge clk);
      bif.tx_start = (n == poke);
      if (n == poke) begin bif.frame_type = 1'b1; bif.frame_length = 5'd3; end
      if (bif.len_error) lerr_cnt++;
      if (bif.tx_done) begin
        done = 1;
        if (b2b) begin bif.tx_start = 1'b1; bif.frame_type = 1'b0; end
      end else begin
        if (n == 0) busy_first = bif.busy;
        line.push_back(bif.tx_out);
        if (bif.tx_en) en_cnt++;
        if (bif.word_rd) rd_pos.push_back(n);
        n++;
      end
    end
    check("done_seen", int'(done), 1);
  endtask

  task automatic verify(input string t, input int nw, input int dur);
    int         bad, glitch, rdbad, nb, base;
    logic [1:0] o;
    logic [7:0] ob;
    nb = exp_sym.size();
    bad = 0; glitch = 0; rdbad = 0;
    check({t, "_dur"}, line.size(), dur);
    check({t, "_en"}, en_cnt, dur);
    check({t, "_busy0"}, busy_first, 1);
    for (int k = 0; k < nb; k++) begin
      base = 16 * k;
      if (base + 15 < line.size()) begin
        o = {line[base + 4], line[base + 12]};
        if (o !== exp_sym[k]) bad++;
        for (int j = 0; j < 8; j++) begin
          if (line[base + j] !== line[base + 4]) glitch++;
          if (line[base + 8 + j] !== line[base + 12]) glitch++;
        end
      end else bad++;
    end
    check({t, "_sym"}, bad, 0);
    check({t, "_glitch"}, glitch, 0);
    check({t, "_nrd"}, rd_pos.size(), nw);
    for (int i = 0; i < rd_pos.size() && i < exp_rd.size(); i++)
      if (rd_pos[i] != exp_rd[i]) rdbad++;
    check({t, "_rdpos"}, rdbad, 0);
    for (int g = 0; g < exp_chk.size(); g++) begin
      ob = 8'h00;
      for (int b = 0; b < 8; b++)
        if (16 * (chk_bit[g] + b) + 4 < line.size()) ob[7 - b] = line[16 * (chk_bit[g] + b) + 4];
      if (g == 0) obs_chk0 = ob;
      check({t, "_chk"}, ob, exp_chk[g]);
    end
    check({t, "_lerr"}, lerr_cnt, 0);
  endtask

  initial begin
    logic [4:0] bad_len [3];
    int         act;
    bad_len = '{5'd3, 5'd0, 5'd17};
    bif.tx_start = 1'b0; bif.frame_type = 1'b0; bif.frame_length = 5'd1;

    repeat (3) @(negedge clk);
    check("reset", {bif.tx_out, bif.tx_en, bif.busy, bif.word_rd, bif.tx_done, bif.len_error}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Master, zero data; frame_length=0 must be ignored for master
    wmem[0] = 16'h0000; fifo_idx = 0; build_exp(1'b0, 1);
    start(1'b0, 5'd0); capture(-1, 0); verify("m0", 1, 544);
    check("m0_hand_chk", obs_chk0, 8'hFF);
    @(negedge clk);
    check("m0_done_pulse", {bif.tx_done, bif.busy, bif.tx_en}, 0);

    // Master, 16'h0001: remainder x^7 mod g = 0x65, check = 0x35
    wmem[0] = 16'h0001; fifo_idx = 0; build_exp(1'b0, 1);
    start(1'b0, 5'd1); capture(-1, 0); verify("m1", 1, 544);
    check("m1_hand_chk", obs_chk0, 8'h35);

    // Slave, 4 zero words
    for (int i = 0; i < 4; i++) wmem[i] = 16'h0000;
    fifo_idx = 0; build_exp(1'b1, 4);
    start(1'b1, 5'd4); capture(-1, 0); verify("s4", 4, 1312);
    check("s4_hand_chk", obs_chk0, 8'hFF);

    // Slave, 16 random words, 4 groups
    for (int i = 0; i < 16; i++) wmem[i] = 16'($urandom);
    fifo_idx = 0; build_exp(1'b1, 16);
    start(1'b1, 5'd16); capture(-1, 0); verify("s16", 16, 4768);
    check("s16_ngrp", exp_chk.size(), 4);

    // Illegal slave lengths
    for (int i = 0; i < 3; i++) begin
      start(1'b1, bad_len[i]);
      @(negedge clk);
      check("le_pulse", bif.len_error, 1);
      act = 0;
      repeat (20) begin
        @(negedge clk);
        if (bif.busy || bif.tx_en || bif.word_rd || bif.len_error) act++;
      end
      check("le_quiet", act, 0);
    end

    // Mid-frame poke with an illegal request, then back-to-back master
    wmem[0] = 16'h8001; fifo_idx = 0; build_exp(1'b0, 1);
    start(1'b0, 5'd1); capture(200, 1); verify("poke", 1, 544);
    wmem[0] = 16'hA5C3; fifo_idx = 0; build_exp(1'b0, 1);
    capture(-1, 0); verify("b2b", 1, 544);

    // Asynchronous reset while in DATA
    wmem[0] = 16'hFFFF; fifo_idx = 0;
    start(1'b0, 5'd1);
    repeat (196) @(negedge clk);
    check("rst_pre", {bif.tx_out, bif.tx_en, bif.busy}, 3'b111);
    rst = 1'b0;
    #1;
    check("rst_async", {bif.tx_out, bif.tx_en, bif.busy}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    wmem[0] = 16'h0001; fifo_idx = 0; build_exp(1'b0, 1);
    start(1'b0, 5'd1); capture(-1, 0); verify("post_rst", 1, 544);
    check("post_rst_chk", obs_chk0, 8'h35);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
